// File: rtl/car_spawn_scheduler.sv
// Frame-paced spawn scheduler for a pool of car movers sharing one spawn-position bus.
// Optional release/drop statistics outputs are compiled in with SPAWN_STATS_EN.
module car_spawn_scheduler #(
  parameter int          NUM_CARS       = 4,
  parameter int          LANE_COUNT     = 4,
  parameter logic [10:0] LANE_X0        = 11'd200,
  parameter logic [10:0] LANE_PITCH     = 11'd64,
  parameter logic [7:0]  MIN_GAP_FRAMES = 8'd20,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                startOfFrame,
  input  logic                enable,
  input  logic [3:0]          playerspeed,
  input  logic [NUM_CARS-1:0] carReady,
  output logic [NUM_CARS-1:0] releaseCar,
  output logic [10:0]         carXinitial,
  output logic [10:0]         redXfinal
`ifdef SPAWN_STATS_EN
  ,
  output logic [15:0]         spawnCount,
  output logic [7:0]          dropCount
`endif
);

  localparam int LB = $clog2(LANE_COUNT);
  localparam int GB = $clog2(NUM_CARS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_GAP, S_SELECT, S_ARMED} state_t;

  state_t              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d, lfsr_next;
  logic [7:0]          gap_cnt_q, gap_cnt_d;
  logic [GB-1:0]       last_grant_q, last_grant_d;
  logic [LB-1:0]       last_lane_q, last_lane_d;
  logic [NUM_CARS-1:0] pending_q, pending_d;
  logic [GB-1:0]       pend_idx_q, pend_idx_d;
  logic [LB-1:0]       lane_q, lane_d;
  logic [10:0]         car_x_q, car_x_d;
  logic [10:0]         red_x_q, red_x_d;

  // Round-robin search state
  logic                found;
  logic [GB-1:0]       win_idx;
  logic [GB-1:0]       rr_idx;
  logic [NUM_CARS-1:0] win_oh;

  logic [LB-1:0]       lane_raw, lane_sel, red_lane;
  logic [10:0]         car_x_sel, red_x_sel;
  logic [7:0]          gap_dec, gap_sub;
  logic                fire;

  assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    rr_idx  = '0;
    for (int i = 1; i <= NUM_CARS; i++) begin
      rr_idx = GB'((int'(last_grant_q) + i) % NUM_CARS);
      if (!found && carReady[rr_idx]) begin
        found   = 1'b1;
        win_idx = rr_idx;
      end
    end
  end

  assign win_oh = {{(NUM_CARS-1){1'b0}}, 1'b1} << win_idx;

  // Never reuse the previous spawn lane; the red-car target is always a different lane.
  assign lane_raw  = lfsr_q[LB-1:0];
  assign lane_sel  = (lane_raw == last_lane_q) ? lane_raw + LB'(1) : lane_raw;
  assign red_lane  = lane_sel + LB'(1) + LB'(lfsr_q[4]);
  assign car_x_sel = LANE_X0 + 11'(lane_sel) * LANE_PITCH;
  assign red_x_sel = LANE_X0 + 11'(red_lane) * LANE_PITCH;

  assign gap_dec = 8'(playerspeed >> 2) + 8'd1;
  assign gap_sub = (gap_cnt_q > gap_dec) ? gap_cnt_q - gap_dec : 8'd0;

  assign fire = (state_q == S_ARMED) && startOfFrame && enable && (|(pending_q & carReady));

  assign releaseCar  = fire ? pending_q : '0;
  assign carXinitial = car_x_q;
  assign redXfinal   = red_x_q;

  always_comb begin
    state_d      = state_q;
    lfsr_d       = startOfFrame ? lfsr_next : lfsr_q;
    gap_cnt_d    = gap_cnt_q;
    last_grant_d = last_grant_q;
    last_lane_d  = last_lane_q;
    pending_d    = pending_q;
    pend_idx_d   = pend_idx_q;
    lane_d       = lane_q;
    car_x_d      = car_x_q;
    red_x_d      = red_x_q;
    if (!enable) begin
      state_d   = S_IDLE;
      pending_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          gap_cnt_d = MIN_GAP_FRAMES;
          state_d   = S_WAIT_GAP;
        end
        S_WAIT_GAP: begin
          if (gap_cnt_q == 8'd0)
            state_d = S_SELECT;
          else if (startOfFrame)
            gap_cnt_d = gap_sub;
        end
        S_SELECT: begin
          if (found) begin
            pending_d  = win_oh;
            pend_idx_d = win_idx;
            lane_d     = lane_sel;
            car_x_d    = car_x_sel;
            red_x_d    = red_x_sel;
            state_d    = S_ARMED;
          end
        end
        S_ARMED: begin
          if (startOfFrame) begin
            pending_d = '0;
            if (fire) begin
              last_grant_d = pend_idx_q;
              last_lane_d  = lane_q;
              gap_cnt_d    = MIN_GAP_FRAMES + {4'b0, lfsr_q[3:0]};
              state_d      = S_WAIT_GAP;
            end else begin
              state_d = S_SELECT;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= S_IDLE;
      lfsr_q       <= LFSR_SEED;
      gap_cnt_q    <= MIN_GAP_FRAMES;
      last_grant_q <= GB'(NUM_CARS - 1);
      last_lane_q  <= '0;
      pending_q    <= '0;
      pend_idx_q   <= '0;
      lane_q       <= '0;
      car_x_q      <= LANE_X0;
      red_x_q      <= LANE_X0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      gap_cnt_q    <= gap_cnt_d;
      last_grant_q <= last_grant_d;
      last_lane_q  <= last_lane_d;
      pending_q    <= pending_d;
      pend_idx_q   <= pend_idx_d;
      lane_q       <= lane_d;
      car_x_q      <= car_x_d;
      red_x_q      <= red_x_d;
    end
  end

`ifdef SPAWN_STATS_EN
  logic        enable_q, enable_d;
  logic [15:0] spawn_cnt_q, spawn_cnt_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic        drop;

  assign drop = (state_q == S_ARMED) && startOfFrame && enable && !fire;

  // An enable rising edge starts a fresh statistics window.
  always_comb begin
    enable_d    = enable;
    spawn_cnt_d = spawn_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (enable && !enable_q) begin
      spawn_cnt_d = '0;
      drop_cnt_d  = '0;
    end else begin
      if (fire && spawn_cnt_q != 16'hFFFF) spawn_cnt_d = spawn_cnt_q + 16'd1;
      if (drop && drop_cnt_q != 8'hFF)     drop_cnt_d  = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      enable_q    <= 1'b0;
      spawn_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      enable_q    <= enable_d;
      spawn_cnt_q <= spawn_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign spawnCount = spawn_cnt_q;
  assign dropCount  = drop_cnt_q;
`endif

endmodule
